// File: rtl/arbitro_memoria_pkg.sv
// Shared types and default parameters for the instruction/data memory arbiter.
package pacote_memoria;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ACESSO  = 2'd1,
    CONCLUI = 2'd2
  } estado_t;

  typedef enum logic {
    DONO_IF = 1'b0,
    DONO_DM = 1'b1
  } dono_t;

  localparam int LAT_PADRAO    = 1;
  localparam int MAX_DM_PADRAO = 3;

endpackage

// File: rtl/arbitro_memoria.sv
// Shares one fixed-latency single-port 64-bit memory between fetch and load/store.
// Data wins arbitration; a starvation counter forces a fetch grant after MAX_DM data grants.
module arbitro_memoria
  import pacote_memoria::*;
#(
  parameter int LAT      = LAT_PADRAO,
  parameter int MAX_DM   = MAX_DM_PADRAO,
  parameter int LARG_END = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [LARG_END-1:0] if_addr,
  output logic                if_ack,
  output logic [31:0]         if_data,
  output logic                atualiza_pc,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [LARG_END-1:0] dm_addr,
  input  logic [63:0]         dm_wdata,
  output logic                dm_ack,
  output logic [63:0]         dm_rdata,
  output logic [LARG_END-1:0] mem_addr,
  output logic                mem_we,
  output logic [63:0]         mem_wdata,
  input  logic [63:0]         mem_rdata
);

  localparam int LW = $clog2(LAT + 1);
  localparam int DW = $clog2(MAX_DM + 1);
  localparam logic [LW-1:0]       LAT_INI    = LW'(LAT - 1);
  localparam logic [DW-1:0]       MAX_DM_V   = DW'(MAX_DM);
  localparam logic [LARG_END-1:0] MASCARA_DM = ~LARG_END'(7);
  localparam logic [LARG_END-1:0] MASCARA_IF = ~LARG_END'(3);

  estado_t             estado_q, estado_d;
  dono_t               dono_q, dono_d;
  logic [LARG_END-1:0] end_q, end_d;
  logic                we_q, we_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [LW-1:0]       cont_lat_q, cont_lat_d;
  logic [DW-1:0]       cont_dm_q, cont_dm_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [63:0]         dm_rdata_q, dm_rdata_d;
  logic                dm_vence;

  // Data wins unless fetch has already waited through MAX_DM consecutive data grants.
  assign dm_vence = dm_req && !(if_req && (cont_dm_q == MAX_DM_V));

  always_comb begin
    estado_d   = estado_q;
    dono_d     = dono_q;
    end_d      = end_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cont_lat_d = cont_lat_q;
    cont_dm_d  = cont_dm_q;
    if_data_d  = if_data_q;
    dm_rdata_d = dm_rdata_q;
    case (estado_q)
      OCIOSO: begin
        if (if_req || dm_req) begin
          estado_d   = ACESSO;
          cont_lat_d = LAT_INI;
          if (dm_vence) begin
            dono_d    = DONO_DM;
            end_d     = dm_addr & MASCARA_DM;
            we_d      = dm_we;
            wdata_d   = dm_wdata;
            cont_dm_d = !if_req ? '0 :
                        (cont_dm_q == MAX_DM_V) ? cont_dm_q : cont_dm_q + DW'(1);
          end else begin
            dono_d    = DONO_IF;
            end_d     = if_addr & MASCARA_IF;
            we_d      = 1'b0;
            wdata_d   = '0;
            cont_dm_d = '0;
          end
        end
      end
      ACESSO: begin
        if (cont_lat_q == '0) begin
          estado_d = CONCLUI;
          if (dono_q == DONO_IF) begin
            if_data_d = end_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end else begin
          cont_lat_d = cont_lat_q - LW'(1);
        end
      end
      CONCLUI: estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= OCIOSO;
      dono_q     <= DONO_IF;
      end_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cont_lat_q <= '0;
      cont_dm_q  <= '0;
      if_data_q  <= '0;
      dm_rdata_q <= '0;
    end else begin
      estado_q   <= estado_d;
      dono_q     <= dono_d;
      end_q      <= end_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cont_lat_q <= cont_lat_d;
      cont_dm_q  <= cont_dm_d;
      if_data_q  <= if_data_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Memory bus is driven only while accessing; the write strobe covers just the first cycle.
  assign mem_addr    = (estado_q == ACESSO) ? end_q : '0;
  assign mem_wdata   = (estado_q == ACESSO) ? wdata_q : '0;
  assign mem_we      = (estado_q == ACESSO) && we_q && (cont_lat_q == LAT_INI);
  assign if_ack      = (estado_q == CONCLUI) && (dono_q == DONO_IF);
  assign dm_ack      = (estado_q == CONCLUI) && (dono_q == DONO_DM);
  assign atualiza_pc = if_ack;
  assign if_data     = if_data_q;
  assign dm_rdata    = dm_rdata_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Self-checking bench: two arbiter instances (LAT=1 and LAT=3) with directed scenarios,
// then random traffic checked every cycle against a transaction-level model.
module tb_arbitro_memoria;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int inst, input string nome, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL g%0d %s: got 0x%0h, expected 0x%0h", inst, nome, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int LAT    = (gi == 0) ? 1 : 3;
    localparam int MAX_DM = 3;
    localparam int ALVO   = (LAT < 2) ? LAT : 2;
    localparam logic [63:0] W0 = 64'hAAAA_BBBB_1111_2222;
    localparam logic [63:0] W8 = 64'h0123_4567_89AB_CDEF;

    logic        rst_n, if_req, dm_req, dm_we, if_ack, atualiza_pc, dm_ack, mem_we;
    logic [63:0] if_addr, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] if_data;
    bit          fin = 1'b0;

    arbitro_memoria #(.LAT(LAT), .MAX_DM(MAX_DM), .LARG_END(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
      .atualiza_pc(atualiza_pc),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Environment memory (driven by the DUT bus) and the model's own copy.
    logic [63:0] env_mem [16];
    logic [63:0] mod_mem [16];
    initial begin
      for (int i = 0; i < 16; i++) begin
        env_mem[i] = {$urandom, $urandom};
        mod_mem[i] = env_mem[i];
      end
      env_mem[0] = W0; mod_mem[0] = W0;
      env_mem[8] = W8; mod_mem[8] = W8;
    end

    // Transaction model: one access occupies cycles 1..LAT after its grant, ack in LAT+1.
    bit          busy = 1'b0, own_dm = 1'b0, m_we = 1'b0;
    int          age = 0, cdm = 0;
    logic [63:0] m_addr = '0, m_wdata = '0;
    logic [31:0] exp_if_data = '0;
    logic [63:0] exp_dm_rdata = '0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy = 1'b0; age = 0; cdm = 0; exp_if_data = '0; exp_dm_rdata = '0;
      end else if (busy) begin
        if (age == 1 && m_we) mod_mem[m_addr[6:3]] = m_wdata;
        if (age == LAT) begin
          if (!own_dm)
            exp_if_data = m_addr[2] ? mod_mem[m_addr[6:3]][63:32] : mod_mem[m_addr[6:3]][31:0];
          else if (!m_we)
            exp_dm_rdata = mod_mem[m_addr[6:3]];
        end
        if (age == LAT + 1) busy = 1'b0;
        else age++;
      end else if (if_req || dm_req) begin
        own_dm  = dm_req && !(if_req && cdm == MAX_DM);
        cdm     = (own_dm && if_req) ? ((cdm < MAX_DM) ? cdm + 1 : MAX_DM) : 0;
        m_addr  = own_dm ? (dm_addr & ~64'h7) : (if_addr & ~64'h3);
        m_we    = own_dm && dm_we;
        m_wdata = own_dm ? dm_wdata : '0;
        busy    = 1'b1;
        age     = 1;
      end
    end

    always @(posedge clk) if (mem_we) env_mem[mem_addr[6:3]] = mem_wdata;

    // Read data is only meaningful in the last access cycle; otherwise it is garbage.
    always @(negedge clk)
      mem_rdata = (busy && age == LAT) ? env_mem[mem_addr[6:3]] : {$urandom, $urandom};

    bit acc, fim;
    always @(negedge clk) begin
      acc = busy && age <= LAT;
      fim = busy && age == LAT + 1;
      check(gi, "mem_addr", mem_addr, acc ? m_addr : 64'h0);
      check(gi, "mem_we", 64'(mem_we), 64'(acc && m_we && age == 1));
      if (!acc || own_dm) check(gi, "mem_wdata", mem_wdata, acc ? m_wdata : 64'h0);
      check(gi, "if_ack", 64'(if_ack), 64'(fim && !own_dm));
      check(gi, "atualiza_pc", 64'(atualiza_pc), 64'(fim && !own_dm));
      check(gi, "dm_ack", 64'(dm_ack), 64'(fim && own_dm));
      check(gi, "if_data", 64'(if_data), 64'(exp_if_data));
      check(gi, "dm_rdata", dm_rdata, exp_dm_rdata);
      if (fim)
        $display("[TB] g%0d cycle %0d %s addr=0x%0h we=%0d", gi, cyc,
                 own_dm ? "DM" : "IF", m_addr, m_we);
    end

    initial begin
      int          t_ack[$];
      int          ordem[$];
      int          k;
      bit          viu;
      logic [4:0]  seq3;
      seq3 = 5'b10111;
      rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Fetch only, upper half of word 0.
      if_req = 1'b1; if_addr = 64'h4;
      @(negedge clk);
      check(gi, "p1 mem_addr", mem_addr, 64'h4);
      repeat (LAT) @(negedge clk);
      check(gi, "p1 if_ack", 64'(if_ack), 64'h1);
      check(gi, "p1 atualiza_pc", 64'(atualiza_pc), 64'h1);
      check(gi, "p1 if_data", 64'(if_data), 64'hAAAABBBB);
      check(gi, "p1 model if_data", 64'(exp_if_data), 64'hAAAABBBB);
      if_req = 1'b0;

      // Store to 0x1D -> word address 0x18, single write strobe.
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h1D; dm_wdata = 64'h55;
      @(negedge clk);
      for (int i = 1; i <= LAT; i++) begin
        @(negedge clk);
        check(gi, "p2 mem_addr", mem_addr, 64'h18);
        check(gi, "p2 mem_we", 64'(mem_we), 64'(i == 1));
      end
      @(negedge clk);
      check(gi, "p2 dm_ack", 64'(dm_ack), 64'h1);
      check(gi, "p2 dm_rdata", dm_rdata, 64'h0);

      // Load from 0x40.
      dm_we = 1'b0; dm_addr = 64'h40;
      @(negedge clk);
      for (int i = 1; i <= LAT; i++) begin
        @(negedge clk);
        check(gi, "p4 mem_addr", mem_addr, 64'h40);
        check(gi, "p4 mem_we", 64'(mem_we), 64'h0);
      end
      @(negedge clk);
      check(gi, "p4 dm_ack", 64'(dm_ack), 64'h1);
      check(gi, "p4 dm_rdata", dm_rdata, W8);
      check(gi, "p4 model dm_rdata", exp_dm_rdata, 64'h0123_4567_89AB_CDEF);

      // Both requesters held: three data grants, then one fetch, then data again.
      if_req = 1'b1; if_addr = 64'h0; dm_addr = 64'h8;
      k = 0;
      while (ordem.size() < 5 && k < 5 * (LAT + 2) + 10) begin
        @(negedge clk); k++;
        if (if_ack) ordem.push_back(0);
        if (dm_ack) ordem.push_back(1);
      end
      if_req = 1'b0; dm_req = 1'b0;
      check(gi, "p3 grant count", 64'(ordem.size()), 64'd5);
      for (int i = 0; i < 5; i++)
        check(gi, $sformatf("p3 grant %0d owner", i),
              64'((i < ordem.size()) ? ordem[i] : 7), 64'(seq3[i]));

      // Back-to-back fetches with if_req held through each ack.
      if_req = 1'b1; if_addr = 64'h10;
      k = 0;
      while (t_ack.size() < 3 && k < 3 * (LAT + 2) + 10) begin
        @(negedge clk); k++;
        if (if_ack) t_ack.push_back(cyc);
      end
      if_req = 1'b0;
      check(gi, "p6 ack count", 64'(t_ack.size()), 64'd3);
      for (int i = 1; i < 3; i++)
        check(gi, "p6 ack spacing",
              64'((i < t_ack.size()) ? t_ack[i] - t_ack[i-1] : 0), 64'(LAT + 2));

      // Reset in the middle of a store.
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h30; dm_wdata = {$urandom, $urandom};
      @(negedge clk);
      repeat (ALVO) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check(gi, "p5 mem_addr", mem_addr, 64'h0);
      check(gi, "p5 mem_we", 64'(mem_we), 64'h0);
      check(gi, "p5 mem_wdata", mem_wdata, 64'h0);
      check(gi, "p5 dm_ack", 64'(dm_ack), 64'h0);
      check(gi, "p5 if_ack", 64'(if_ack), 64'h0);
      check(gi, "p5 atualiza_pc", 64'(atualiza_pc), 64'h0);
      check(gi, "p5 if_data", 64'(if_data), 64'h0);
      check(gi, "p5 dm_rdata", dm_rdata, 64'h0);
      dm_req = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      viu = 1'b0;
      repeat (LAT + 3) begin
        @(negedge clk);
        if (dm_ack || if_ack) viu = 1'b1;
      end
      check(gi, "p5 ack after reset", 64'(viu), 64'h0);
      if_req = 1'b1; if_addr = 64'h30;
      viu = 1'b0; k = 0;
      while (!viu && k < LAT + 4) begin
        @(negedge clk); k++;
        viu = if_ack;
      end
      if_req = 1'b0;
      check(gi, "p5 fetch after reset", 64'(viu), 64'h1);

      // Random traffic, including occasional early request drops.
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (if_req) begin
          if (if_ack) begin
            if ($urandom_range(0, 1) == 1) if_addr = {$urandom, $urandom};
            else if_req = 1'b0;
          end else if ($urandom_range(0, 31) == 0) if_req = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = {$urandom, $urandom};
        end
        if (dm_req) begin
          if (dm_ack) begin
            if ($urandom_range(0, 1) == 1) begin
              dm_addr = {$urandom, $urandom}; dm_we = 1'($urandom_range(0, 1));
              dm_wdata = {$urandom, $urandom};
            end else dm_req = 1'b0;
          end else if ($urandom_range(0, 31) == 0) dm_req = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
          dm_req = 1'b1; dm_addr = {$urandom, $urandom};
          dm_we = 1'($urandom_range(0, 1)); dm_wdata = {$urandom, $urandom};
        end
      end
      if_req = 1'b0; dm_req = 1'b0;
      repeat (LAT + 3) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int w;
    w = 0;
    while (!(g[0].fin && g[1].fin) && w < 20000) begin
      @(posedge clk);
      w++;
    end
    n_tests++;
    if (!(g[0].fin && g[1].fin)) begin
      n_fail++;
      $display("FAIL timeout: done flags %0d%0d, expected 11", g[0].fin, g[1].fin);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
